alarm_ctrl: RTL and testbench

Consumer of the one-cycle alarm-match pulse produced by the time comparator. It arms, rings, snoozes and silences the alarm, and drives a gated square-wave buzzer for the Basys board. It sits between the comparator/clock-counter logic and the buzzer pin and LEDs. All timing derives from an external one-cycle 1 Hz tick.

---
 rtl/alarm_ctrl_if.sv | 29 ++
 rtl/alarm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm controller and its surroundings: the
// comparator/timebase/buttons on one side, the buzzer pin and LEDs on the other.
interface alarm_ctrl_if #(
  parameter int MAX_SNOOZE = 3
);
  localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);

  logic             tick_1hz;
  logic             H;
  logic             enable;
  logic             snooze_btn;
  logic             stop_btn;
  logic             buzzer;
  logic             ringing;
  logic             snoozing;
  logic [SNZ_W-1:0] snooze_cnt;

  // Side that produces the alarm events and button pulses.
  modport master (
    output tick_1hz, H, enable, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozing, snooze_cnt
  );

  // The alarm controller itself.
  modport slave (
    input  tick_1hz, H, enable, snooze_btn, stop_btn,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: arms on the comparator match pulse, rings with a gated
// square-wave tone, allows a bounded number of snoozes, and auto-silences
// after a timeout. All second-based timing comes from the external 1 Hz tick.
module alarm_ctrl #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 25000
) (
  input  logic       clk,
  input  logic       rst,
  alarm_ctrl_if.slave bus
);

  localparam int SEC_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int SEC_W   = $clog2(SEC_MAX);
  localparam int SNZ_W   = $clog2(MAX_SNOOZE + 1);
  localparam int TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_S - 1);
  localparam logic [SNZ_W-1:0]  SNZ_MAX     = SNZ_W'(MAX_SNOOZE);
  localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(TONE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [SEC_W-1:0]    sec_q,    sec_d;
  logic [SNZ_W-1:0]    snz_q,    snz_d;
  logic [TONE_W-1:0]   tcnt_q,   tcnt_d;
  logic                beep_q,   beep_d;
  logic                tone_q,   tone_d;
  logic                buzz_q,   buzz_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= '0;
      snz_q   <= '0;
      tcnt_q  <= '0;
      beep_q  <= 1'b0;
      tone_q  <= 1'b0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
      tcnt_q  <= tcnt_d;
      beep_q  <= beep_d;
      tone_q  <= tone_d;
      buzz_q  <= buzz_d;
    end
  end

  // Next-state and datapath: priority enable > stop > snooze > tick > H.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    sec_d   = sec_q;
    snz_d   = snz_q;
    tcnt_d  = tcnt_q;
    beep_d  = beep_q;
    tone_d  = tone_q;

    unique case (state_q)
      IDLE: begin
        sec_d  = '0;
        snz_d  = '0;
        tcnt_d = '0;
        beep_d = 1'b0;
        tone_d = 1'b0;
        // A match while disarmed is simply dropped.
        if (bus.enable && bus.H) begin
          state_d = RING;
          beep_d  = 1'b1;
        end
      end

      RING: begin
        // Tone divider free-runs for as long as the alarm rings.
        if (tcnt_q == TONE_LAST) begin
          tcnt_d = '0;
          tone_d = ~tone_q;
        end else begin
          tcnt_d = tcnt_q + TONE_W'(1);
        end

        if (!bus.enable || bus.stop_btn) begin
          state_d = IDLE;
          sec_d   = '0;
          snz_d   = '0;
          tcnt_d  = '0;
          beep_d  = 1'b0;
          tone_d  = 1'b0;
        end else if (bus.snooze_btn && (snz_q < SNZ_MAX)) begin
          // The button consumes this cycle; a coincident tick is discarded.
          state_d = SNOOZE;
          sec_d   = '0;
          snz_d   = snz_q + SNZ_W'(1);
          tcnt_d  = '0;
          beep_d  = 1'b0;
          tone_d  = 1'b0;
        end else if (bus.tick_1hz) begin
          // An exhausted snooze press is ignored, so the timeout keeps running.
          if (sec_q == RING_LAST) begin
            state_d = IDLE;
            sec_d   = '0;
            snz_d   = '0;
            tcnt_d  = '0;
            beep_d  = 1'b0;
            tone_d  = 1'b0;
          end else begin
            sec_d  = sec_q + SEC_W'(1);
            beep_d = ~beep_q;
          end
        end
      end

      SNOOZE: begin
        tcnt_d = '0;
        beep_d = 1'b0;
        tone_d = 1'b0;
        if (!bus.enable || bus.stop_btn) begin
          state_d = IDLE;
          sec_d   = '0;
          snz_d   = '0;
        end else if (bus.tick_1hz) begin
          if (sec_q == SNOOZE_LAST) begin
            // Re-enter RING with a fresh timeout and tone phase.
            state_d = RING;
            sec_d   = '0;
            beep_d  = 1'b1;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        sec_d   = '0;
        snz_d   = '0;
        tcnt_d  = '0;
        beep_d  = 1'b0;
        tone_d  = 1'b0;
      end
    endcase

    // Buzzer is registered from next-state values so it never lingers a cycle
    // after leaving RING.
    buzz_d = tone_d & beep_d & (state_d == RING);
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    bus.ringing    = (state_q == RING);
    bus.snoozing   = (state_q == SNOOZE);
    bus.snooze_cnt = snz_q;
    bus.buzzer     = buzz_q;
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus pushes expected outputs into a
// queue after each driven edge; a negedge monitor pops and compares.
module tb_alarm_ctrl;

  localparam int RT = 5;
  localparam int ST = 3;
  localparam int MS = 2;
  localparam int TD = 4;

  typedef struct {
    string      name;
    logic       ring;
    logic       snz;
    logic [1:0] cnt;
    logic       buz;
    logic       chk_buz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alarm_ctrl_if #(.MAX_SNOOZE(MS)) bus ();

  alarm_ctrl #(
    .RING_TIMEOUT_S(RT),
    .SNOOZE_S      (ST),
    .MAX_SNOOZE    (MS),
    .TONE_DIV      (TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per falling edge, mid-cycle after the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " state"},
            {4'd0, bus.ringing, bus.snoozing, bus.snooze_cnt},
            {4'd0, e.ring, e.snz, e.cnt});
      if (e.chk_buz)
        check({e.name, " buzzer"}, {7'd0, bus.buzzer}, {7'd0, e.buz});
    end
  end

  // Advance past one active edge and return the one-cycle pulses to 0.
  task automatic step();
    @(posedge clk);
    #1;
    bus.tick_1hz   = 1'b0;
    bus.H          = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic ring, input logic snz,
                            input logic [1:0] cnt, input logic buz, input logic chk_buz);
    exp_t e;
    e.name = name; e.ring = ring; e.snz = snz; e.cnt = cnt;
    e.buz = buz; e.chk_buz = chk_buz;
    exp_q.push_back(e);
  endtask

  task automatic pulse_h();      bus.H = 1'b1;          step(); endtask
  task automatic pulse_tick();   bus.tick_1hz = 1'b1;   step(); endtask
  task automatic pulse_snooze(); bus.snooze_btn = 1'b1; step(); endtask
  task automatic pulse_stop();   bus.stop_btn = 1'b1;   step(); endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tick_1hz = 1'b0; bus.H = 1'b0; bus.enable = 1'b0;
    bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;

    // Reset state.
    rst = 1'b1;
    step();
    expect_out("reset", 0, 0, 2'd0, 0, 1);
    step();
    rst = 1'b0;
    bus.enable = 1'b1;

    // 1: ring, tone toggles every TD clocks, auto-off after RT ticks.
    pulse_h();
    expect_out("t1 ring k0", 1, 0, 2'd0, 0, 1);
    for (int k = 1; k < 10; k++) begin
      step();
      expect_out($sformatf("t1 tone k%0d", k), 1, 0, 2'd0, logic'((k >> 2) & 1), 1);
    end
    pulse_tick();
    expect_out("t1 beep off", 1, 0, 2'd0, 0, 1);
    ticks(RT - 2);
    expect_out("t1 last sec", 1, 0, 2'd0, 0, 0);
    pulse_tick();
    expect_out("t1 timeout", 0, 0, 2'd0, 0, 1);

    // 2: snooze, snooze press ignored while snoozing, back to RING.
    pulse_h();
    pulse_snooze();
    expect_out("t2 snooze", 0, 1, 2'd1, 0, 1);
    pulse_snooze();
    expect_out("t2 snz in snz", 0, 1, 2'd1, 0, 1);
    ticks(ST - 1);
    expect_out("t2 snz last", 0, 1, 2'd1, 0, 1);
    pulse_tick();
    expect_out("t2 re-ring", 1, 0, 2'd1, 0, 1);
    pulse_stop();
    expect_out("t2 stop", 0, 0, 2'd0, 0, 1);

    // 3: snooze limit, then auto-off from the last RING entry.
    pulse_h();
    pulse_snooze();
    ticks(ST);
    expect_out("t3 ring cnt1", 1, 0, 2'd1, 0, 1);
    pulse_snooze();
    expect_out("t3 snooze2", 0, 1, 2'd2, 0, 1);
    ticks(ST);
    expect_out("t3 ring cnt2", 1, 0, 2'd2, 0, 1);
    pulse_snooze();
    expect_out("t3 snz sat", 1, 0, 2'd2, 0, 0);
    ticks(RT - 1);
    expect_out("t3 pre-off", 1, 0, 2'd2, 0, 0);
    pulse_tick();
    expect_out("t3 auto-off", 0, 0, 2'd0, 0, 1);

    // 4: stop beats snooze; stop from SNOOZE; snooze beats a coincident tick.
    pulse_h();
    bus.snooze_btn = 1'b1; bus.stop_btn = 1'b1;
    step();
    expect_out("t4 stop>snz", 0, 0, 2'd0, 0, 1);
    pulse_h();
    pulse_snooze();
    pulse_stop();
    expect_out("t4 snz stop", 0, 0, 2'd0, 0, 1);
    pulse_h();
    bus.snooze_btn = 1'b1; bus.tick_1hz = 1'b1;
    step();
    expect_out("t4 snz>tick", 0, 1, 2'd1, 0, 1);
    ticks(ST - 1);
    expect_out("t4 snz hold", 0, 1, 2'd1, 0, 1);
    pulse_tick();
    expect_out("t4 re-ring", 1, 0, 2'd1, 0, 1);
    pulse_stop();

    // 5: disarmed match dropped; disarm mid-RING silences immediately.
    bus.enable = 1'b0;
    pulse_h();
    expect_out("t5 h dropped", 0, 0, 2'd0, 0, 1);
    bus.enable = 1'b1;
    step();
    expect_out("t5 no latch", 0, 0, 2'd0, 0, 1);
    pulse_h();
    repeat (TD) step();
    expect_out("t5 buzz on", 1, 0, 2'd0, 1, 1);
    bus.enable = 1'b0;
    step();
    expect_out("t5 disarm", 0, 0, 2'd0, 0, 1);
    bus.enable = 1'b1;

    // 6: H during RING does not restart; reset mid-SNOOZE.
    pulse_h();
    ticks(3);
    pulse_h();
    expect_out("t6 h ignored", 1, 0, 2'd0, 0, 0);
    pulse_tick();
    expect_out("t6 sec4", 1, 0, 2'd0, 0, 0);
    pulse_tick();
    expect_out("t6 off", 0, 0, 2'd0, 0, 1);
    pulse_h();
    pulse_snooze();
    expect_out("t6 snoozing", 0, 1, 2'd1, 0, 1);
    rst = 1'b1;
    step();
    expect_out("t6 rst", 0, 0, 2'd0, 0, 1);
    rst = 1'b0;
    pulse_h();
    expect_out("t6 post-rst", 1, 0, 2'd0, 0, 1);
    pulse_stop();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
